dram_read_responder: RTL

- Serves the DRAM read request interface issued by the image sender: it accepts address/length requests and turns them into AXI4 INCR read bursts on the PS DDR port.
- Returns the read beats as dram_read_data / dram_read_data_valid.
- Splits bursts that would cross a 4 KB boundary into two AXI bursts.
- Sits in the clk_pixel domain between the image sender and the AXI HP master port.

---
 rtl/dram_read_responder_if.sv | 33 +++
 rtl/dram_read_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dram_read_responder_if.sv
// AXI4 read-channel bundle between the DRAM read responder (master) and the HP port (slave).
interface dram_read_responder_if #(
  parameter int DRAM_ADDR_WIDTH = 39,
  parameter int DRAM_DATA_WIDTH = 128,
  parameter int AXI_ID_WIDTH    = 1
);
  logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]                 m_axi_arlen;
  logic [2:0]                 m_axi_arsize;
  logic [1:0]                 m_axi_arburst;
  logic [3:0]                 m_axi_arcache;
  logic [2:0]                 m_axi_arprot;
  logic [AXI_ID_WIDTH-1:0]    m_axi_arid;
  logic                       m_axi_arvalid;
  logic                       m_axi_arready;
  logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]                 m_axi_rresp;
  logic                       m_axi_rlast;
  logic                       m_axi_rvalid;
  logic                       m_axi_rready;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache,
           m_axi_arprot, m_axi_arid, m_axi_arvalid, m_axi_rready,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache,
           m_axi_arprot, m_axi_arid, m_axi_arvalid, m_axi_rready,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
  );
endinterface

// File: rtl/dram_read_responder.sv
// Turns address/length read requests into AXI4 INCR read bursts, splitting at 4 KB
// boundaries, and returns the read beats one cycle after each R handshake.
module dram_read_responder #(
  parameter int DRAM_ADDR_WIDTH = 39,
  parameter int DRAM_DATA_WIDTH = 128,
  parameter int AXI_ID_WIDTH    = 1
) (
  input  logic                       clk_pixel,
  input  logic                       dram_reader_resetn,
  input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
  input  logic [7:0]                 dram_read_len,
  input  logic                       dram_read_en,
  output logic                       dram_read_busy,
  output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
  output logic                       dram_read_data_valid,
  output logic                       read_error,
  output logic                       request_dropped,
  dram_read_responder_if.master      m_axi
);
  localparam int BEAT_BYTES = DRAM_DATA_WIDTH / 8;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

  typedef logic [DRAM_ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t                     state_q, state_d;
  addr_t                      araddr_q, araddr_d;
  logic [7:0]                 arlen_q, arlen_d;
  logic                       arvalid_q, arvalid_d;
  logic                       rready_q, rready_d;
  addr_t                      next_addr_q, next_addr_d;
  logic [7:0]                 next_len_q, next_len_d;
  logic                       remaining_q, remaining_d;
  logic [7:0]                 beat_cnt_q, beat_cnt_d;
  logic [DRAM_DATA_WIDTH-1:0] data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       error_q, error_d;
  logic                       dropped_q, dropped_d;

  addr_t       req_addr_s;
  logic [8:0]  req_beats_s;
  logic [12:0] bytes_to_bound_s;
  logic [8:0]  to_bound_s;
  logic        beat_s;
  logic        last_beat_s;
  logic        unused_addr_lsb_s;

  // Beats left before the next 4 KB page boundary decide whether the request splits.
  assign req_addr_s        = {dram_read_addr[DRAM_ADDR_WIDTH-1:BEAT_SHIFT], {BEAT_SHIFT{1'b0}}};
  assign unused_addr_lsb_s = ^dram_read_addr[BEAT_SHIFT-1:0];
  assign req_beats_s       = {1'b0, dram_read_len} + 9'd1;
  assign bytes_to_bound_s  = 13'd4096 - {1'b0, req_addr_s[11:0]};
  assign to_bound_s        = 9'(bytes_to_bound_s >> BEAT_SHIFT);
  assign beat_s            = m_axi.m_axi_rvalid & rready_q;
  assign last_beat_s       = (beat_cnt_q == arlen_q);

  assign dram_read_busy       = (state_q != IDLE);
  assign dram_read_data       = data_q;
  assign dram_read_data_valid = valid_q;
  assign read_error           = error_q;
  assign request_dropped      = dropped_q;

  assign m_axi.m_axi_araddr  = araddr_q;
  assign m_axi.m_axi_arlen   = arlen_q;
  assign m_axi.m_axi_arvalid = arvalid_q;
  assign m_axi.m_axi_rready  = rready_q;
  assign m_axi.m_axi_arsize  = 3'(BEAT_SHIFT);
  assign m_axi.m_axi_arburst = 2'b01;
  assign m_axi.m_axi_arcache = 4'b0011;
  assign m_axi.m_axi_arprot  = 3'b000;
  assign m_axi.m_axi_arid    = {AXI_ID_WIDTH{1'b0}};

  // Next-state and output decode of the request/address/data sequencer.
  always_comb begin
    state_d     = state_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    next_addr_d = next_addr_q;
    next_len_d  = next_len_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    error_d     = error_q;
    dropped_d   = dropped_q | (dram_read_en & (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (dram_read_en) begin
          araddr_d  = req_addr_s;
          arvalid_d = 1'b1;
          state_d   = ADDR;
          if (req_beats_s <= to_bound_s) begin
            arlen_d     = dram_read_len;
            remaining_d = 1'b0;
          end else begin
            arlen_d     = 8'(to_bound_s - 9'd1);
            next_addr_d = req_addr_s + (addr_t'(to_bound_s) << BEAT_SHIFT);
            next_len_d  = 8'(req_beats_s - to_bound_s - 9'd1);
            remaining_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (m_axi.m_axi_arready) begin
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
          beat_cnt_d = 8'd0;
          state_d    = DATA;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      DATA: begin
        if (beat_s) begin
          data_d  = m_axi.m_axi_rdata;
          valid_d = 1'b1;
          // The burst always ends on the arlen-th beat; a misplaced rlast only flags.
          error_d = error_q | (m_axi.m_axi_rresp != 2'b00) | (m_axi.m_axi_rlast != last_beat_s);
          if (last_beat_s) begin
            rready_d = 1'b0;
            if (remaining_q) begin
              araddr_d    = next_addr_q;
              arlen_d     = next_len_q;
              remaining_d = 1'b0;
              arvalid_d   = 1'b1;
              state_d     = ADDR;
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      default: begin
        state_d   = IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_pixel) begin
    if (!dram_reader_resetn) begin
      state_q     <= IDLE;
      araddr_q    <= '0;
      arlen_q     <= 8'd0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      next_addr_q <= '0;
      next_len_q  <= 8'd0;
      remaining_q <= 1'b0;
      beat_cnt_q  <= 8'd0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      next_addr_q <= next_addr_d;
      next_len_q  <= next_len_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
      dropped_q   <= dropped_d;
    end
  end
endmodule
